intdiv_seqdiv: RTL and testbench

//  Iterative, parametrised integer divider: the clocked successor to the combinational array divider.

---
 rtl/intdiv_seqdiv.sv | 158 +++++++++++++++
 tb/tb_intdiv_seqdiv.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/intdiv_seqdiv.sv
// Sequential restoring divider, one quotient bit per cycle.
// Signed/unsigned N-bit quotient and remainder with valid/ready handshakes.
//
// Ports:
//   clk, rst              rising-edge clock, async active-high reset
//   in_valid, in_ready    operand handshake (x dividend, y divisor)
//   out_valid, out_ready  result handshake (z quotient, r remainder)
//   div0                  divisor was zero: z = all ones, r = x
//   ovf                   signed overflow (-2^(N-1) / -1): z = 100..0, r = 0
module intdiv_seqdiv #(
    parameter int N      = 8,
    parameter bit SIGNED = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] z,
    output logic [N-1:0] r,
    output logic         div0,
    output logic         ovf
);

    localparam int CW = (N > 2) ? $clog2(N) : 1;

    localparam logic [CW-1:0] CONE  = CW'(1);
    localparam logic [CW-1:0] CLAST = CW'(N - 1);
    localparam logic [N-1:0]  ONE   = N'(1);
    localparam logic [N-1:0]  ONES  = '1;
    localparam logic [N-1:0]  MINV  = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic [N:0]    rem;
    logic [N-1:0]  quo;
    logic [N-1:0]  dvs;
    logic [N-1:0]  xq;
    logic          sgn_q;
    logic          sgn_r;
    logic          d0_q;
    logic          ov_q;

    logic          sx;
    logic          sy;
    logic [N-1:0]  xmag;
    logic [N-1:0]  ymag;
    logic [N:0]    shifted;
    logic [N+1:0]  diff;
    logic [N-1:0]  zfix;
    logic [N-1:0]  rfix;

    // Magnitudes of operands; |-2^(N-1)| fits as an N-bit unsigned value.
    assign sx   = SIGNED && x[N-1];
    assign sy   = SIGNED && y[N-1];
    assign xmag = sx ? (~x + ONE) : x;
    assign ymag = sy ? (~y + ONE) : y;

    // quo holds the not-yet-consumed dividend bits at the top and
    // collects quotient bits at the bottom as they are produced.
    assign shifted = {rem[N-1:0], quo[N-1]};
    assign diff    = {1'b0, shifted} - {2'b00, dvs};

    always_comb begin
        zfix = quo;
        rfix = rem[N-1:0];
        if (SIGNED && sgn_q) zfix = ~quo + ONE;
        if (SIGNED && sgn_r) rfix = ~rem[N-1:0] + ONE;
        if (d0_q) begin
            zfix = ONES;
            rfix = xq;
        end else if (ov_q) begin
            zfix = MINV;
            rfix = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            rem       <= '0;
            quo       <= '0;
            dvs       <= '0;
            xq        <= '0;
            sgn_q     <= 1'b0;
            sgn_r     <= 1'b0;
            d0_q      <= 1'b0;
            ov_q      <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            z         <= '0;
            r         <= '0;
            div0      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        quo      <= xmag;
                        dvs      <= ymag;
                        xq       <= x;
                        rem      <= '0;
                        sgn_q    <= sx ^ sy;
                        sgn_r    <= sx;
                        d0_q     <= (y == '0);
                        ov_q     <= SIGNED && (x == MINV) && (y == ONES);
                        count    <= CLAST;
                        in_ready <= 1'b0;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    // Borrow out of the trial subtraction means restore.
                    if (diff[N+1]) begin
                        rem <= shifted;
                        quo <= {quo[N-2:0], 1'b0};
                    end else begin
                        rem <= diff[N:0];
                        quo <= {quo[N-2:0], 1'b1};
                    end
                    if (count == '0) begin
                        state <= FIX;
                    end else begin
                        count <= count - CONE;
                    end
                end
                FIX: begin
                    z         <= zfix;
                    r         <= rfix;
                    div0      <= d0_q;
                    ovf       <= ov_q;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_intdiv_seqdiv.sv
// Bench for intdiv_seqdiv: N=8 vector table and corner sequences,
// plus an exhaustive N=4 sweep in signed and unsigned mode.
module tb_intdiv_seqdiv;

    typedef struct {
        bit         sgn;
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] z;
        logic [7:0] r;
        bit         d0;
        bit         ov;
    } vec_t;

    typedef struct {
        logic [7:0] z;
        logic [7:0] r;
        bit         d0;
        bit         ov;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       iv8 = 1'b0, or8 = 1'b1;
    logic [7:0] x8 = '0, y8 = '0;
    logic       ir8s, ov8s, d8s, f8s, ir8u, ov8u, d8u, f8u;
    logic [7:0] z8s, r8s, z8u, r8u;

    logic       iv4 = 1'b0, or4 = 1'b1;
    logic [3:0] x4 = '0, y4 = '0;
    logic       ir4s, ov4s, d4s, f4s, ir4u, ov4u, d4u, f4u;
    logic [3:0] z4s, r4s, z4u, r4u;

    int nvec = 0;
    int nbad = 0;
    exp_t q8[$];
    exp_t q4[$];

    always #5 clk = ~clk;

    intdiv_seqdiv #(.N(8), .SIGNED(1'b1)) u8s (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8s),
        .x(x8), .y(y8), .out_valid(ov8s), .out_ready(or8),
        .z(z8s), .r(r8s), .div0(d8s), .ovf(f8s));

    intdiv_seqdiv #(.N(8), .SIGNED(1'b0)) u8u (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8u),
        .x(x8), .y(y8), .out_valid(ov8u), .out_ready(or8),
        .z(z8u), .r(r8u), .div0(d8u), .ovf(f8u));

    intdiv_seqdiv #(.N(4), .SIGNED(1'b1)) u4s (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4s),
        .x(x4), .y(y4), .out_valid(ov4s), .out_ready(or4),
        .z(z4s), .r(r4s), .div0(d4s), .ovf(f4s));

    intdiv_seqdiv #(.N(4), .SIGNED(1'b0)) u4u (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4u),
        .x(x4), .y(y4), .out_valid(ov4u), .out_ready(or4),
        .z(z4u), .r(r4u), .div0(d4u), .ovf(f4u));

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op8(input vec_t v);
        int t;
        exp_t e;
        t = 0;
        while (!(ir8s && ir8u) && t < 50) begin
            tick();
            t++;
        end
        chk("ready8", 32'(ir8s && ir8u), 1);
        x8 = v.x;
        y8 = v.y;
        iv8 = 1'b1;
        tick();
        iv8 = 1'b0;
        q8.push_back('{v.z, v.r, v.d0, v.ov});
        t = 0;
        while (!(v.sgn ? ov8s : ov8u) && t < 50) begin
            tick();
            t++;
        end
        chk("latency8", t, 9);
        e = q8.pop_front();
        chk("z8", v.sgn ? z8s : z8u, e.z);
        chk("r8", v.sgn ? r8s : r8u, e.r);
        chk("div0_8", v.sgn ? d8s : d8u, e.d0);
        chk("ovf8", v.sgn ? f8s : f8u, e.ov);
        if (or8) tick();
    endtask

    function automatic exp_t model4(input bit sgn, input logic [3:0] a,
                                    input logic [3:0] b);
        exp_t e;
        int xs, ys;
        e = '{4'd0, 4'd0, 1'b0, 1'b0};
        if (b == 4'd0) begin
            e = '{8'h0F, {4'd0, a}, 1'b1, 1'b0};
        end else if (sgn) begin
            xs = int'($signed(a));
            ys = int'($signed(b));
            if (xs == -8 && ys == -1) begin
                e = '{8'h08, 8'h00, 1'b0, 1'b1};
            end else begin
                e.z = {4'd0, 4'(xs / ys)};
                e.r = {4'd0, 4'(xs % ys)};
            end
        end else begin
            e.z = {4'd0, a / b};
            e.r = {4'd0, a % b};
        end
        return e;
    endfunction

    vec_t vt[11];

    initial begin
        exp_t e;
        int t;

        vt[0]  = '{1, 8'd30, 8'd7,  8'd4,  8'd2,  0, 0};
        vt[1]  = '{1, 8'h88, 8'h0B, 8'hF6, 8'hF6, 0, 0};
        vt[2]  = '{1, 8'h07, 8'hFE, 8'hFD, 8'h01, 0, 0};
        vt[3]  = '{1, 8'h80, 8'hFF, 8'h80, 8'h00, 0, 1};
        vt[4]  = '{1, 8'h05, 8'h00, 8'hFF, 8'h05, 1, 0};
        vt[5]  = '{1, 8'hF0, 8'h00, 8'hFF, 8'hF0, 1, 0};
        vt[6]  = '{1, 8'h81, 8'h02, 8'hC1, 8'hFF, 0, 0};
        vt[7]  = '{0, 8'd200, 8'd7, 8'd28, 8'd4,  0, 0};
        vt[8]  = '{0, 8'hFF, 8'hFF, 8'h01, 8'h00, 0, 0};
        vt[9]  = '{0, 8'h05, 8'h00, 8'hFF, 8'h05, 1, 0};
        vt[10] = '{0, 8'h80, 8'hFF, 8'h00, 8'h80, 0, 0};

        tick();
        tick();
        chk("rst_in_ready", ir8s, 1);
        chk("rst_out_valid", ov8s, 0);
        chk("rst_z", z8s, 0);
        chk("rst_r", r8s, 0);
        chk("rst_flags", {d8s, f8s}, 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 11; i++) op8(vt[i]);

        // Hold result in DONE; new operands must be ignored.
        or8 = 1'b0;
        op8(vt[0]);
        for (int k = 0; k < 5; k++) begin
            x8 = 8'd99;
            y8 = 8'd1;
            iv8 = 1'b1;
            tick();
            chk("hold_z", z8s, 8'd4);
            chk("hold_r", r8s, 8'd2);
            chk("hold_valid", ov8s, 1);
            chk("hold_in_ready", ir8s, 0);
        end
        iv8 = 1'b0;
        or8 = 1'b1;
        tick();
        chk("release_in_ready", ir8s, 1);
        chk("release_out_valid", ov8s, 0);
        chk("keep_z", z8s, 8'd4);
        op8(vt[2]);

        // Reset in the middle of CALC (count = 3).
        x8 = 8'd100;
        y8 = 8'd3;
        iv8 = 1'b1;
        tick();
        iv8 = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", ir8s, 1);
        chk("midrst_out_valid", ov8s, 0);
        tick();
        rst = 1'b0;
        repeat (12) begin
            tick();
            if (ov8s) chk("stale_valid", ov8s, 0);
        end
        op8('{1, 8'd9, 8'd3, 8'd3, 8'd0, 0, 0});

        // Exhaustive N=4 sweep, both modes in lockstep.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                t = 0;
                while (!(ir4s && ir4u) && t < 50) begin
                    tick();
                    t++;
                end
                x4 = 4'(a);
                y4 = 4'(b);
                iv4 = 1'b1;
                tick();
                iv4 = 1'b0;
                q4.push_back(model4(1'b1, 4'(a), 4'(b)));
                q4.push_back(model4(1'b0, 4'(a), 4'(b)));
                t = 0;
                while (!(ov4s && ov4u) && t < 50) begin
                    tick();
                    t++;
                end
                chk("latency4", t, 5);
                e = q4.pop_front();
                chk("n4s_z", {4'd0, z4s}, e.z);
                chk("n4s_r", {4'd0, r4s}, e.r);
                chk("n4s_flags", {d4s, f4s}, {e.d0, e.ov});
                e = q4.pop_front();
                chk("n4u_z", {4'd0, z4u}, e.z);
                chk("n4u_r", {4'd0, r4u}, e.r);
                chk("n4u_flags", {d4u, f4u}, {e.d0, e.ov});
                tick();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
